// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants for the core-side inport/outport bridge.
//   DEFAULT_DATA_WIDTH : default word width of both ports
//   STATUS_WIDTH       : width of the status word seen by the core
//   *_LSB / *_BIT      : field positions inside the status word
//   sat_count2()       : clamps a FIFO occupancy to the 2-bit status field
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned STATUS_WIDTH       = 16;

    localparam int unsigned TX_CNT_LSB = 0;
    localparam int unsigned RX_CNT_LSB = 2;
    localparam int unsigned TX_OVF_BIT = 4;
    localparam int unsigned RX_UNF_BIT = 5;

    // A full 4-deep FIFO reads back as 3 in the 2-bit field.
    function automatic logic [1:0] sat_count2(input int unsigned count);
        logic [1:0] res;
        if (count > 32'd3) begin
            res = 2'd3;
        end else begin
            res = 2'(count);
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write request and data; accepted when not full, or when
//                  full and a pop happens on the same edge
//   pop          : read request; ignored when empty
//   dout         : head word, 0 while empty
//   count        : occupancy, 0..DEPTH
//   full, empty  : occupancy flags
// Error policy (overflow/underflow) is the instantiating block's business.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push needs, so full-with-pop still accepts.
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// -----------------------------------------------------------------------------
// io_port_bridge
// Peripheral-side end of the core's inport/outport interface.
//   clk, reset_n    : clock, asynchronous active-low reset
//   outport         : core output word, pushed into TX on r_outport
//   r_outport       : core output strobe
//   inport          : RX head word to the core (0 when empty)
//   r_inport        : core input strobe, pops the RX head
//   ext_out_data    : TX head word to the device (0 when empty)
//   ext_out_valid   : TX non-empty
//   ext_out_ready   : device accepts ext_out_data
//   ext_in_data     : word from the device
//   ext_in_valid    : device word valid
//   ext_in_ready    : RX not full
//   status          : {10'b0, rx_underflow, tx_overflow, rx_cnt[1:0], tx_cnt[1:0]}
//   err_clear       : clears both sticky error bits
// -----------------------------------------------------------------------------
module io_port_bridge
    import io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned RX_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   outport,
    input  logic                    r_outport,
    output logic [DATA_WIDTH-1:0]   inport,
    input  logic                    r_inport,
    output logic [DATA_WIDTH-1:0]   ext_out_data,
    output logic                    ext_out_valid,
    input  logic                    ext_out_ready,
    input  logic [DATA_WIDTH-1:0]   ext_in_data,
    input  logic                    ext_in_valid,
    output logic                    ext_in_ready,
    output logic [STATUS_WIDTH-1:0] status,
    input  logic                    err_clear
);

    localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH + 1);
    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH + 1);

    logic [TX_CNT_W-1:0] tx_count;
    logic                tx_full;
    logic                tx_empty;
    logic                tx_pop;

    logic [RX_CNT_W-1:0] rx_count;
    logic                rx_full;
    logic                rx_empty;
    logic                rx_push;

    logic                tx_ovf_q, tx_ovf_d;
    logic                rx_unf_q, rx_unf_d;
    logic                tx_ovf_evt;
    logic                rx_unf_evt;

    // ---------------------------------------------------------------- TX path
    assign ext_out_valid = ~tx_empty;
    assign tx_pop        = ext_out_valid & ext_out_ready;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (r_outport),
        .pop     (tx_pop),
        .din     (outport),
        .dout    (ext_out_data),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    // A push into a full FIFO is only lost when nothing drains on that edge.
    assign tx_ovf_evt = r_outport & tx_full & ~tx_pop;

    // ---------------------------------------------------------------- RX path
    // Ready comes from the registered count only, so a same-edge core pop
    // never opens a slot for the device.
    assign ext_in_ready = ~rx_full;
    assign rx_push      = ext_in_valid & ext_in_ready;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (r_inport),
        .din     (ext_in_data),
        .dout    (inport),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign rx_unf_evt = r_inport & rx_empty;

    // ------------------------------------------------------------ error bits
    // An error event on the same edge as err_clear keeps the bit set.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (err_clear) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end
        if (tx_ovf_evt) begin
            tx_ovf_d = 1'b1;
        end
        if (rx_unf_evt) begin
            rx_unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    // ---------------------------------------------------------------- status
    always_comb begin
        status                   = '0;
        status[TX_CNT_LSB +: 2]  = sat_count2(32'(tx_count));
        status[RX_CNT_LSB +: 2]  = sat_count2(32'(rx_count));
        status[TX_OVF_BIT]       = tx_ovf_q;
        status[RX_UNF_BIT]       = rx_unf_q;
    end

endmodule

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;

    logic        clk;
    logic        reset_n;
    logic [15:0] outport;
    logic        r_outport;
    logic [15:0] inport;
    logic        r_inport;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready;
    logic [15:0] ext_in_data;
    logic        ext_in_valid;
    logic        ext_in_ready;
    logic [15:0] status;
    logic        err_clear;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected words, pushed by stimulus, popped by the monitor.
    logic [15:0] txq [$];
    logic [15:0] rxq [$];

    io_port_bridge #(
        .DATA_WIDTH (16),
        .TX_DEPTH   (4),
        .RX_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .outport       (outport),
        .r_outport     (r_outport),
        .inport        (inport),
        .r_inport      (r_inport),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .status        (status),
        .err_clear     (err_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next falling edge and drop one-shot strobes.
    task automatic step();
        @(negedge clk);
        #1;
        r_outport    = 1'b0;
        r_inport     = 1'b0;
        ext_in_valid = 1'b0;
        err_clear    = 1'b0;
    endtask

    // Monitor: samples late in the low phase, when this cycle's inputs are set.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n) begin
                if (ext_out_valid && ext_out_ready) begin
                    if (txq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL tx_unexpected: got %h expected none", ext_out_data);
                    end else begin
                        exp = txq.pop_front();
                        chk("tx_word", ext_out_data, exp);
                    end
                end
                if (r_inport) begin
                    exp = (rxq.size() != 0) ? rxq.pop_front() : 16'h0000;
                    chk("rx_word", inport, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n       = 1'b0;
        outport       = '0;
        r_outport     = 1'b0;
        r_inport      = 1'b0;
        ext_out_ready = 1'b0;
        ext_in_data   = '0;
        ext_in_valid  = 1'b0;
        err_clear     = 1'b0;

        // Reset state
        step();
        chk("rst_valid", {15'b0, ext_out_valid}, 16'h0000);
        chk("rst_ready", {15'b0, ext_in_ready}, 16'h0001);
        chk("rst_status", status, 16'h0000);
        chk("rst_inport", inport, 16'h0000);
        chk("rst_outdata", ext_out_data, 16'h0000);
        reset_n = 1'b1;

        // Single TX word, then drain
        step();
        r_outport = 1'b1;
        outport   = 16'hA5A5;
        txq.push_back(16'hA5A5);
        step();
        chk("tx1_valid", {15'b0, ext_out_valid}, 16'h0001);
        chk("tx1_data", ext_out_data, 16'hA5A5);
        chk("tx1_status", status, 16'h0001);
        ext_out_ready = 1'b1;
        step();
        ext_out_ready = 1'b0;
        chk("tx1_valid_after", {15'b0, ext_out_valid}, 16'h0000);
        chk("tx1_status_after", status, 16'h0000);

        // Five pushes into a 4-deep TX: fifth is dropped
        for (int i = 1; i <= 5; i++) begin
            r_outport = 1'b1;
            outport   = 16'(i);
            if (i <= 4) txq.push_back(16'(i));
            step();
        end
        chk("ovf_status", status, 16'h0013);
        chk("ovf_head", ext_out_data, 16'h0001);
        ext_out_ready = 1'b1;
        repeat (4) step();
        ext_out_ready = 1'b0;
        chk("ovf_drained", {15'b0, ext_out_valid}, 16'h0000);
        chk("ovf_sticky", status, 16'h0010);
        err_clear = 1'b1;
        step();
        chk("ovf_cleared", status, 16'h0000);

        // RX fill from device
        ext_in_valid = 1'b1; ext_in_data = 16'h1111; step();
        ext_in_valid = 1'b1; ext_in_data = 16'h2222; step();
        ext_in_valid = 1'b1; ext_in_data = 16'h3333; step();
        ext_in_valid = 1'b1; ext_in_data = 16'h4444; step();
        chk("rx_full_ready", {15'b0, ext_in_ready}, 16'h0000);
        chk("rx_head", inport, 16'h1111);
        chk("rx_full_status", status, 16'h000C);
        // Core pops while device offers 5555: full blocks the push this edge
        r_inport     = 1'b1;
        rxq.push_back(16'h1111);
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h5555;
        step();
        chk("rx_head2", inport, 16'h2222);
        chk("rx_ready_up", {15'b0, ext_in_ready}, 16'h0001);
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h5555;
        step();
        chk("rx_refull", {15'b0, ext_in_ready}, 16'h0000);
        rxq.push_back(16'h2222);
        rxq.push_back(16'h3333);
        rxq.push_back(16'h4444);
        rxq.push_back(16'h5555);
        for (int i = 0; i < 4; i++) begin
            r_inport = 1'b1;
            step();
        end
        chk("rx_empty_status", status, 16'h0000);
        chk("rx_empty_inport", inport, 16'h0000);

        // Underflow and sticky clear
        r_inport = 1'b1;
        step();
        chk("unf_inport", inport, 16'h0000);
        chk("unf_set", status, 16'h0020);
        err_clear = 1'b1;
        step();
        chk("unf_clear", status, 16'h0000);
        err_clear = 1'b1;
        r_inport  = 1'b1;
        step();
        chk("unf_clear_loses", status, 16'h0020);
        // Empty pop with a same-edge device push: push still lands
        r_inport     = 1'b1;
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h7777;
        step();
        chk("unf_push_status", status, 16'h0024);
        chk("unf_push_word", inport, 16'h7777);
        rxq.push_back(16'h7777);
        r_inport  = 1'b1;
        err_clear = 1'b1;
        step();
        chk("unf_final", status, 16'h0000);

        // TX full, push and pop on the same edge
        for (int i = 1; i <= 4; i++) begin
            r_outport = 1'b1;
            outport   = 16'hC000 | 16'(i);
            txq.push_back(16'hC000 | 16'(i));
            step();
        end
        r_outport     = 1'b1;
        outport       = 16'hBEEF;
        txq.push_back(16'hBEEF);
        ext_out_ready = 1'b1;
        step();
        chk("full_pp_status", status, 16'h0003);
        chk("full_pp_head", ext_out_data, 16'hC002);
        repeat (3) step();
        chk("full_pp_last", {15'b0, ext_out_valid}, 16'h0001);
        chk("full_pp_lastw", ext_out_data, 16'hBEEF);
        step();
        ext_out_ready = 1'b0;
        chk("full_pp_done", {15'b0, ext_out_valid}, 16'h0000);

        // Asynchronous reset mid-stream
        r_outport = 1'b1; outport = 16'h0A01; ext_in_valid = 1'b1; ext_in_data = 16'h0B01;
        step();
        r_outport = 1'b1; outport = 16'h0A02; ext_in_valid = 1'b1; ext_in_data = 16'h0B02;
        step();
        r_outport = 1'b1; outport = 16'h0A03;
        step();
        chk("pre_rst_status", status, 16'h000B);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {15'b0, ext_out_valid}, 16'h0000);
        chk("arst_inport", inport, 16'h0000);
        chk("arst_ready", {15'b0, ext_in_ready}, 16'h0001);
        chk("arst_status", status, 16'h0000);
        step();
        reset_n = 1'b1;

        // Clean restart
        r_outport = 1'b1;
        outport   = 16'h1234;
        txq.push_back(16'h1234);
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h9876;
        step();
        chk("restart_tx", ext_out_data, 16'h1234);
        chk("restart_rx", inport, 16'h9876);
        chk("restart_status", status, 16'h0005);
        ext_out_ready = 1'b1;
        r_inport      = 1'b1;
        rxq.push_back(16'h9876);
        step();
        ext_out_ready = 1'b0;
        chk("restart_done", status, 16'h0000);

        step();
        chk("txq_left", 16'(txq.size()), 16'h0000);
        chk("rxq_left", 16'(rxq.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Peripheral-side end of the processor's inport/outport interface.
- Captures words the core writes to `outport` (strobed by `r_outport`) into a TX FIFO and drains them to an external device over valid/ready.
- Accepts words from the external device over valid/ready into an RX FIFO and presents the head word on `inport`; the core consumes it with `r_inport`.
- Sits between the register file and board-level peripherals.

Parameters:
- DATA_WIDTH, 16, word width of both ports.
- TX_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- outport  input  DATA_WIDTH  word driven by the core's output register.
- r_outport  input  1  core output strobe; push `outport` into TX.
- inport  output  DATA_WIDTH  RX head word, to the core.
- r_inport  input  1  core input strobe; pop RX head.
- ext_out_data  output  DATA_WIDTH  TX head word.
- ext_out_valid  output  1  TX non-empty.
- ext_out_ready  input  1  device accepts `ext_out_data`.
- ext_in_data  input  DATA_WIDTH  device word.
- ext_in_valid  input  1  device word valid.
- ext_in_ready  output  1  RX not full.
- status  output  16  {10'b0, rx_underflow, tx_overflow, rx_count[1:0], tx_count[1:0]}; count fields are saturated to 2 bits, i.e. count 4 reads as 3.
- err_clear  input  1  clears both sticky error bits.

Behaviour:
- Reset (asynchronous, active-low):
  - Both FIFOs empty; pointers and counts 0.
  - `inport`=0, `ext_out_data`=0, `ext_out_valid`=0, `ext_in_ready`=1, `status`=0.
  - Reset mid-transfer discards all buffered words. No handshake completes in a cycle where reset_n is low.
- Sampling:
  - `outport`, `r_outport` and `r_inport` are sampled at the rising edge.
  - The core changes them only while clk is low, so they are stable at the edge.
- TX push: `r_outport`=1 at an edge.
  - Not full: write `outport` at the write pointer; pointer +1 mod TX_DEPTH; count +1.
  - Full and no pop this edge: word dropped; `tx_overflow` set (sticky).
- TX pop: `ext_out_valid`=1 and `ext_out_ready`=1 at an edge; read pointer +1.
- TX simultaneous push and pop: both succeed and count is unchanged, including when full. The push is not an overflow in that case.
- TX outputs are first-word-fall-through:
  - `ext_out_data` = mem[rd_ptr] when non-empty, else 0.
  - `ext_out_valid` = (tx_count != 0), combinational from registered count.
  - Zero-cycle path: a word pushed at edge N is visible at the device after edge N.
- RX push:
  - `ext_in_ready` = (rx_count != RX_DEPTH), combinational from registered count.
  - A push occurs on an edge with `ext_in_valid`=1 and `ext_in_ready`=1.
  - No push is accepted while full, even if the core pops the same cycle; `ready` deasserts for that cycle.
- RX pop: `r_inport`=1 at an edge.
  - Non-empty: read pointer +1; count -1.
  - Empty: ignored; `rx_underflow` set (sticky). A same-edge push still completes.
- RX output:
  - `inport` = mem[rd_ptr] when non-empty, else 0 (first-word-fall-through, combinational).
  - The core's negedge capture therefore sees the word valid since the preceding rising edge.
- RX simultaneous push and pop when non-empty and not full: count unchanged.
- Counts are $clog2(DEPTH+1) bits wide. Pointers wrap modulo DEPTH. No pointer arithmetic is exposed.
- `err_clear`=1 at an edge clears both sticky bits. An error event on the same edge wins, so the bit stays set.
- `r_outport` and `r_inport` may both be asserted on one edge; they are fully independent.

Decomposition:
- Shared package `io_pkg`: DATA_WIDTH default and `status` bit-index constants (TX_CNT_LSB=0, RX_CNT_LSB=2, TX_OVF_BIT=4, RX_UNF_BIT=5).
- One sub-module `sync_fifo` (params WIDTH, DEPTH):
  - Ports: push, pop, din, dout (first-word-fall-through, 0 when empty), count, full, empty.
  - Simultaneous push/pop on full is allowed.
  - Instantiated twice. The overflow/underflow policy lives in the top, not in the FIFO.

Test Plan:
- Reset, then `r_outport` with 16'hA5A5 and `ext_out_ready`=0 → `ext_out_valid`=1, `ext_out_data`=16'hA5A5, `status`=16'h0001. Raise ready for one cycle → valid=0, status=0.
- Push 16'h0001..16'h0005 via `r_outport` with ready=0 → first four buffered; status tx bits=3 and bit4=1. Drain with ready=1 → data 1,2,3,4 in order, then valid=0.
- Device pushes 16'h1111, 16'h2222, 16'h3333, 16'h4444 → `ext_in_ready`=0 after the 4th.
  - `inport`=16'h1111; `r_inport` → `inport`=16'h2222 and ready=1 next cycle.
  - Device valid held with 16'h5555 is accepted only at the edge after ready rises.
- `r_inport` on empty RX → `inport` stays 0, status bit5=1. `err_clear` → bit5=0. `err_clear` together with another empty pop → bit5 stays 1.
- TX full plus `r_outport` (16'hBEEF) plus ext pop on the same edge → no overflow; count stays 4; 16'hBEEF is the last word drained.
- Assert reset_n=0 asynchronously mid-stream with 3 TX and 2 RX words → immediately valid=0, `inport`=0, ready=1, status=0; pointers restart cleanly after release.
